lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Load/store unit between the core execute stage and d_cache_v1 (data memory).
//  Takes one load/store request at a time and decodes RV32 funct3 into mem_wstrb.
//  Drives the single-cycle d_cache_v1 port and returns byte/half loads extended to 32 bits.
//  Reports bound violations (d_cache_miss), misalignment and illegal funct3 as faults.
// PARAMETERS
//  ADDR_W             32  byte-address width on core and cache sides
//  LOAD_ZERO_ON_FAULT 1   1: resp_rdata forced to 0 when resp_fault!=0; 0: last assembled value
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous, active-low reset
//  req_valid    in   1       core request valid
//  req_ready    out  1       LSU idle; request accepted when req_valid&&req_ready
//  req_is_load  in   1       1 load, 0 store
//  req_funct3   in   3       RV32 load/store funct3
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data (low bits significant)
//  resp_valid   out  1       one-cycle completion pulse
//  resp_rdata   out  32      extended load data (0 for stores)
//  resp_fault   out  2       00 ok, 01 bound miss, 10 misaligned, 11 illegal funct3
//  fault_addr   out  ADDR_W  byte address of faulting access (valid with resp_valid)
//  data_enable  out  1       to cache
//  data_read    out  1       to cache, 1 = read
//  mem_wstrb    out  4       to cache byte strobe
//  ram_address  out  ADDR_W  to cache
//  ram_store    out  32      to cache; data always in low bits (cache takes [7:0]/[15:0]/[31:0])
//  ram_fetch    in   32      from cache; registered, valid the cycle after a read access
//  d_cache_miss in   1       from cache; combinational out-of-bounds flag, sampled in ACCESS
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; every other output 0. Asserting rst_n low mid-op aborts
//   immediately; data_enable drops asynchronously; no response is issued.
//  FSM: IDLE -> ACCESS -> (load) LOAD_WAIT -> ... -> RESP -> IDLE.
//  IDLE: req_ready=1. On accept, register the request and check:
//   funct3 not in {000,001,010,100,101} (load) / {000,001,010} (store) -> fault 11;
//   half with addr[0]=1, or word with addr[1:0]!=0 -> fault 10.
//   A pre-fault goes to ACCESS with data_enable held 0, then to RESP.
//  ACCESS (1 cycle): data_enable=1, data_read=is_load, address/strobe/data from registers.
//   Stores drive wstrb: SB 1<<a[1:0], SH a[1]?1100:0011, SW 1111; loads drive wstrb=0000.
//   d_cache_miss=1 -> fault 01, fault_addr=ram_address, go to RESP. For a store the cache
//   suppresses the write itself, so no rollback is needed.
//   Store ok -> RESP (write commits at this edge). Load ok -> LOAD_WAIT.
//  LOAD_WAIT: capture ram_fetch; select lane by a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  RESP: resp_valid=1 for exactly 1 cycle; rdata/fault/fault_addr stable this cycle; -> IDLE.
//  Latency (accept in cycle N): store resp at N+2, load resp at N+3, pre-fault resp at N+2.
//   Throughput is 1 request per 3 (store) / 4 (load) cycles.
//  The LSU never drives data_enable outside ACCESS, so d_cache_miss is 0 otherwise.
//  Cache-side outputs come from registers/state decode only (glitch-free, no req_* paths).
// CONFIGURATION
//  MISALIGN_SPLIT_EN defined: misaligned half/word accesses are not faulted. They split into
//   n=2/4 byte accesses at addr+k, k=0..n-1 (counter, ADDR_W wrap allowed).
//   Store byte k: ram_store[7:0]=wdata[8k+7:8k], wstrb=1<<(addr+k)[1:0].
//   Load: each byte does ACCESS+LOAD_WAIT and is assembled little-endian, extended at the end.
//   The first miss aborts the remaining bytes: fault 01, fault_addr=addr+k. Earlier store
//   bytes stay written.
//   Latency: store N+n+1, load N+2n+1. Illegal funct3 still faults.
//  Undefined: misaligned accesses fault 10 as above. No split logic or counter is compiled.
// TESTING
//  SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> store resp N+2; load resp N+3, rdata 0xDEADBEEF, fault 00
//  SB 0x13 wdata 0x80 -> wstrb 1000; then LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080
//  SH 0x12 wdata 0x8001 -> wstrb 1100; LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001
//  LW 0x800 with bound 0x400 -> data_enable pulse, resp fault 01, fault_addr 0x800, rdata 0
//  LW 0x11, macro off -> fault 10, data_enable never high; macro on, mem[0x10]=0x44332211,
//   mem[0x14]=0x88776655 -> rdata 0x55443322, resp at N+9
//  funct3 011 load -> fault 11; reset asserted in LOAD_WAIT -> no resp_valid, req_ready=1

Source files
------------

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - load/store unit driving the single-cycle d_cache_v1 port
// Optional MISALIGN_SPLIT_EN: misaligned half/word accesses become per-byte accesses.
module lsu_mem_stage #(
   parameter int ADDR_W             = 32,
   parameter bit LOAD_ZERO_ON_FAULT = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_load,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [1:0]        resp_fault,
   output logic [ADDR_W-1:0] fault_addr,
   output logic              data_enable,
   output logic              data_read,
   output logic [3:0]        mem_wstrb,
   output logic [ADDR_W-1:0] ram_address,
   output logic [31:0]       ram_store,
   input  logic [31:0]       ram_fetch,
   input  logic              d_cache_miss
);
   typedef enum logic [1:0] {IDLE, ACCESS, LOAD_WAIT, RESP} state_t;
   localparam logic [1:0] F_OK = 2'b00, F_MISS = 2'b01, F_ALIGN = 2'b10, F_ILL = 2'b11;

   state_t            state_q, state_d;
   logic              is_load_q, is_load_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        fault_q, fault_d;
   logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
   logic [31:0]       rdata_q, rdata_d;
`ifdef MISALIGN_SPLIT_EN
   logic              split_q, split_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              last_byte;
   logic [31:0]       asm_data;
`endif
   logic [ADDR_W-1:0] acc_addr;
   logic [31:0]       lane_data;
   logic              acc_en;
   logic              illegal, misaligned;

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
      case (f3)
         3'b000:  return {{24{v[7]}}, v[7:0]};
         3'b001:  return {{16{v[15]}}, v[15:0]};
         3'b100:  return {24'b0, v[7:0]};
         3'b101:  return {16'b0, v[15:0]};
         default: return v;
      endcase
   endfunction

   always_comb begin
      if (req_is_load)
         illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      else
         illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   end

`ifdef MISALIGN_SPLIT_EN
   assign acc_addr  = addr_q + ADDR_W'(cnt_q);
   assign last_byte = !split_q || (cnt_q == ((funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3));
   assign asm_data  = rdata_q | ({24'b0, lane_data[7:0]} << {cnt_q, 3'b000});
`else
   assign acc_addr  = addr_q;
`endif

   // Pre-faulted requests still pass through ACCESS, but never enable the cache.
   assign acc_en      = (state_q == ACCESS) && (fault_q == F_OK);
   assign data_enable = acc_en;
   assign data_read   = acc_en && is_load_q;
   assign ram_address = acc_addr;
   assign lane_data   = ram_fetch >> {acc_addr[1:0], 3'b000};

   always_comb begin
      mem_wstrb = 4'b0000;
      ram_store = wdata_q;
      if (acc_en && !is_load_q) begin
         case (funct3_q[1:0])
            2'b00:   mem_wstrb = 4'b0001 << acc_addr[1:0];
            2'b01:   mem_wstrb = acc_addr[1] ? 4'b1100 : 4'b0011;
            default: mem_wstrb = 4'b1111;
         endcase
`ifdef MISALIGN_SPLIT_EN
         if (split_q) begin
            mem_wstrb = 4'b0001 << acc_addr[1:0];
            ram_store = (wdata_q >> {cnt_q, 3'b000}) & 32'h0000_00FF;
         end
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      is_load_d    = is_load_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      rdata_d      = rdata_q;
`ifdef MISALIGN_SPLIT_EN
      split_d      = split_q;
      cnt_d        = cnt_q;
`endif
      req_ready    = (state_q == IDLE);
      resp_valid   = (state_q == RESP);
      case (state_q)
         IDLE: if (req_valid) begin
            state_d      = ACCESS;
            is_load_d    = req_is_load;
            funct3_d     = req_funct3;
            addr_d       = req_addr;
            wdata_d      = req_wdata;
            rdata_d      = '0;
            fault_d      = F_OK;
            fault_addr_d = '0;
`ifdef MISALIGN_SPLIT_EN
            split_d      = 1'b0;
            cnt_d        = 2'd0;
`endif
            if (illegal) begin
               fault_d      = F_ILL;
               fault_addr_d = req_addr;
            end else if (misaligned) begin
`ifdef MISALIGN_SPLIT_EN
               split_d      = 1'b1;
`else
               fault_d      = F_ALIGN;
               fault_addr_d = req_addr;
`endif
            end
         end
         ACCESS: begin
            if (fault_q != F_OK) begin
               state_d = RESP;
            end else if (d_cache_miss) begin
               fault_d      = F_MISS;
               fault_addr_d = acc_addr;
               state_d      = RESP;
            end else if (is_load_q) begin
               state_d = LOAD_WAIT;
            end else begin
               state_d = RESP;
`ifdef MISALIGN_SPLIT_EN
               if (!last_byte) begin
                  state_d = ACCESS;
                  cnt_d   = cnt_q + 2'd1;
               end
`endif
            end
         end
         LOAD_WAIT: begin
            state_d = RESP;
            rdata_d = extend(funct3_q, lane_data);
`ifdef MISALIGN_SPLIT_EN
            if (split_q) begin
               rdata_d = last_byte ? extend(funct3_q, asm_data) : asm_data;
               if (!last_byte) begin
                  state_d = ACCESS;
                  cnt_d   = cnt_q + 2'd1;
               end
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign resp_rdata = (LOAD_ZERO_ON_FAULT && (fault_q != F_OK)) ? 32'h0 : rdata_q;
   assign resp_fault = fault_q;
   assign fault_addr = fault_addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         is_load_q    <= 1'b0;
         funct3_q     <= 3'b000;
         addr_q       <= '0;
         wdata_q      <= '0;
         fault_q      <= F_OK;
         fault_addr_q <= '0;
         rdata_q      <= '0;
`ifdef MISALIGN_SPLIT_EN
         split_q      <= 1'b0;
         cnt_q        <= 2'd0;
`endif
      end else begin
         state_q      <= state_d;
         is_load_q    <= is_load_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         rdata_q      <= rdata_d;
`ifdef MISALIGN_SPLIT_EN
         split_q      <= split_d;
         cnt_q        <= cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed self-checking bench for lsu_mem_stage
// Behavioural d_cache_v1 model with a 0x400-byte bound; MISALIGN_SPLIT_EN selects expectations.
module tb_lsu_mem_stage;
   localparam logic [31:0] BOUND = 32'h0000_0400;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_load = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_fault;
   logic [31:0] fault_addr;
   logic        data_enable;
   logic        data_read;
   logic [3:0]  mem_wstrb;
   logic [31:0] ram_address;
   logic [31:0] ram_store;
   logic [31:0] ram_fetch;
   logic        d_cache_miss;

   logic [31:0] mem [0:255];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu_mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .fault_addr(fault_addr), .data_enable(data_enable), .data_read(data_read),
      .mem_wstrb(mem_wstrb), .ram_address(ram_address), .ram_store(ram_store),
      .ram_fetch(ram_fetch), .d_cache_miss(d_cache_miss)
   );

   // Cache model: combinational bound check, registered read, write data taken from low bits.
   assign d_cache_miss = data_enable && (ram_address >= BOUND);

   always @(posedge clk) begin
      int lo;
      if (data_enable && !d_cache_miss) begin
         if (data_read) begin
            ram_fetch <= mem[ram_address[9:2]];
         end else begin
            lo = mem_wstrb[0] ? 0 : mem_wstrb[1] ? 1 : mem_wstrb[2] ? 2 : 3;
            for (int b = 0; b < 4; b++)
               if (mem_wstrb[b]) mem[ram_address[9:2]][8*b +: 8] <= ram_store[8*(b-lo) +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xact(input string tag, input logic ld, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                       input logic [31:0] exp_rd, input logic [1:0] exp_f,
                       input logic [31:0] exp_fa, input logic [3:0] exp_strb, input int exp_en);
      int lat;
      int en_cnt;
      logic [3:0] strb_seen;
      @(negedge clk);
      chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_is_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; en_cnt = 0; strb_seen = 4'b0000;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(negedge clk);
         if (data_enable) begin
            en_cnt++;
            strb_seen = strb_seen | mem_wstrb;
         end
         if (resp_valid) begin
            lat = i;
            chk({tag, "_rdata"}, resp_rdata, exp_rd);
            chk({tag, "_fault"}, {30'b0, resp_fault}, {30'b0, exp_f});
            if (exp_f != 2'b00) chk({tag, "_faddr"}, fault_addr, exp_fa);
         end
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_en_cycles"}, en_cnt, exp_en);
      chk({tag, "_wstrb"}, {28'b0, strb_seen}, {28'b0, exp_strb});
      @(negedge clk);
      chk({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
   endtask

   task automatic abort_at(input string tag, input int stage);
      @(negedge clk);
      req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 1; i < stage; i++) @(negedge clk);
      @(negedge clk);
      if (stage == 1) chk({tag, "_en_before"}, {31'b0, data_enable}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk({tag, "_en"}, {31'b0, data_enable}, 32'd0);
      chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({tag, "_no_resp"}, {31'b0, resp_valid}, 32'd0);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      #2;
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_outputs", {data_enable, data_read, mem_wstrb, resp_fault, 24'b0},  32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_ram_address", ram_address, 32'd0);
      chk("rst_ram_store", ram_store, 32'd0);
      chk("rst_fault_addr", fault_addr, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      xact("sw_pre10", 1'b0, 3'b010, 32'h10, 32'h4433_2211, 2, 32'h0, 2'b00, 32'h0, 4'b1111, 1);
      xact("sw_pre14", 1'b0, 3'b010, 32'h14, 32'h8877_6655, 2, 32'h0, 2'b00, 32'h0, 4'b1111, 1);
`ifdef MISALIGN_SPLIT_EN
      xact("lw_mis11", 1'b1, 3'b010, 32'h11, 32'h0, 9, 32'h5544_3322, 2'b00, 32'h0, 4'b0000, 4);
`else
      xact("lw_mis11", 1'b1, 3'b010, 32'h11, 32'h0, 2, 32'h0, 2'b10, 32'h11, 4'b0000, 0);
`endif
      xact("sw_10", 1'b0, 3'b010, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 2'b00, 32'h0, 4'b1111, 1);
      xact("lw_10", 1'b1, 3'b010, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, 2'b00, 32'h0, 4'b0000, 1);
      xact("sb_13", 1'b0, 3'b000, 32'h13, 32'h0000_0080, 2, 32'h0, 2'b00, 32'h0, 4'b1000, 1);
      xact("lb_13", 1'b1, 3'b000, 32'h13, 32'h0, 3, 32'hFFFF_FF80, 2'b00, 32'h0, 4'b0000, 1);
      xact("lbu_13", 1'b1, 3'b100, 32'h13, 32'h0, 3, 32'h0000_0080, 2'b00, 32'h0, 4'b0000, 1);
      xact("sh_12", 1'b0, 3'b001, 32'h12, 32'h0000_8001, 2, 32'h0, 2'b00, 32'h0, 4'b1100, 1);
      xact("lh_12", 1'b1, 3'b001, 32'h12, 32'h0, 3, 32'hFFFF_8001, 2'b00, 32'h0, 4'b0000, 1);
      xact("lhu_12", 1'b1, 3'b101, 32'h12, 32'h0, 3, 32'h0000_8001, 2'b00, 32'h0, 4'b0000, 1);
      xact("lw_10_mixed", 1'b1, 3'b010, 32'h10, 32'h0, 3, 32'h8001_BEEF, 2'b00, 32'h0, 4'b0000, 1);
      xact("lbu_11", 1'b1, 3'b100, 32'h11, 32'h0, 3, 32'h0000_00BE, 2'b00, 32'h0, 4'b0000, 1);
      xact("lw_800_miss", 1'b1, 3'b010, 32'h800, 32'h0, 2, 32'h0, 2'b01, 32'h800, 4'b0000, 1);
      xact("sw_400_miss", 1'b0, 3'b010, 32'h400, 32'h1234_5678, 2, 32'h0, 2'b01, 32'h400, 4'b1111, 1);
      xact("ld_f3_011", 1'b1, 3'b011, 32'h20, 32'h0, 2, 32'h0, 2'b11, 32'h20, 4'b0000, 0);
      xact("st_f3_100", 1'b0, 3'b100, 32'h24, 32'h55, 2, 32'h0, 2'b11, 32'h24, 4'b0000, 0);

      abort_at("rst_in_access", 1);
      abort_at("rst_in_load_wait", 2);

      xact("sb_20_after_rst", 1'b0, 3'b000, 32'h21, 32'h0000_00A5, 2, 32'h0, 2'b00, 32'h0, 4'b0010, 1);
      xact("lbu_21", 1'b1, 3'b100, 32'h21, 32'h0, 3, 32'h0000_00A5, 2'b00, 32'h0, 4'b0000, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
